// File: rtl/dma_mc_burst_gen_if.sv
// Descriptor-queue and burst-request bus of the multi-channel DMA burst generator.
// master: the generator itself; slave: descriptor producers plus the AXI master consuming req_*.
interface dma_mc_burst_gen_if #(
  parameter int N_CH    = 2,
  parameter int DATA_W  = 32,
  parameter int BYTES_W = 32
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BPB  = DATA_W / 8;

  logic [N_CH-1:0]         desc_valid_i;
  logic [N_CH-1:0]         desc_ready_o;
  logic [N_CH*32-1:0]      desc_addr_i;
  logic [N_CH*BYTES_W-1:0] desc_bytes_i;
  logic [N_CH-1:0]         abort_i;
  logic                    req_valid_o;
  logic                    req_ready_i;
  logic [31:0]             req_addr_o;
  logic [7:0]              req_len_o;
  logic [2:0]              req_size_o;
  logic [BPB-1:0]          req_strb_o;
  logic                    req_last_o;
  logic [CH_W-1:0]         req_ch_o;
  logic [N_CH-1:0]         done_o;
  logic [N_CH-1:0]         error_o;
  logic [31:0]             err_addr_o;
  logic                    busy_o;

  modport master (
    input  desc_valid_i, desc_addr_i, desc_bytes_i, abort_i, req_ready_i,
    output desc_ready_o, req_valid_o, req_addr_o, req_len_o, req_size_o,
           req_strb_o, req_last_o, req_ch_o, done_o, error_o, err_addr_o, busy_o
  );

  modport slave (
    output desc_valid_i, desc_addr_i, desc_bytes_i, abort_i, req_ready_i,
    input  desc_ready_o, req_valid_o, req_addr_o, req_len_o, req_size_o,
           req_strb_o, req_last_o, req_ch_o, done_o, error_o, err_addr_o, busy_o
  );
endinterface

// File: rtl/dma_mc_burst_gen.sv
// Round-robin descriptor arbiter that splits each (addr, num_bytes) descriptor into
// AXI INCR burst requests limited by MAX_BEATS and the BOUNDARY crossing rule.
module dma_mc_burst_gen #(
  parameter int N_CH      = 2,
  parameter int DATA_W    = 32,
  parameter int BYTES_W   = 32,
  parameter int MAX_BEATS = 256,
  parameter int BOUNDARY  = 4096
) (
  input logic clk,
  input logic rst,
  dma_mc_burst_gen_if.master bus
);
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BPB     = DATA_W / 8;
  localparam int LOG_BPB = $clog2(BPB);
  localparam int RW      = BYTES_W + 1;
  localparam int CW      = (RW > 33) ? RW : 33;
  localparam int unsigned N_CH_U = N_CH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] BURST = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         state;
  logic [CH_W-1:0]    rr_ptr;
  logic [CH_W-1:0]    cur_ch;
  logic [31:0]        cur_addr;
  logic [RW-1:0]      remaining;
  logic [LOG_BPB-1:0] tail;
  logic [8:0]         burst_n;
  logic               err_flag;

  logic               gnt_any;
  logic [CH_W-1:0]    gnt_ch;
  logic [BYTES_W-1:0] gnt_bytes;
  logic [CW-1:0]      room;
  logic [CW-1:0]      n_calc;
  logic               last_calc;
  logic [BPB-1:0]     strb_calc;

  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_ch  = '0;
    for (int unsigned i = 0; i < N_CH_U; i++) begin
      idx = (32'(rr_ptr) + i) % N_CH_U;
      if (!gnt_any && bus.desc_valid_i[CH_W'(idx)]) begin
        gnt_any = 1'b1;
        gnt_ch  = CH_W'(idx);
      end
    end
  end

  assign gnt_bytes = bus.desc_bytes_i[BYTES_W*gnt_ch +: BYTES_W];

  // Beats in this burst: smallest of what is left, the burst cap and the room before the boundary.
  always_comb begin
    room   = (CW'(BOUNDARY) - CW'(cur_addr & 32'(BOUNDARY - 1))) >> LOG_BPB;
    n_calc = CW'(remaining);
    if (n_calc > CW'(MAX_BEATS)) n_calc = CW'(MAX_BEATS);
    if (n_calc > room)           n_calc = room;
    last_calc = (n_calc == CW'(remaining));
    strb_calc = '1;
    if (last_calc && tail != '0) strb_calc = (BPB'(1) << tail) - BPB'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      cur_ch         <= '0;
      cur_addr       <= '0;
      remaining      <= '0;
      tail           <= '0;
      burst_n        <= '0;
      err_flag       <= 1'b0;
      bus.req_addr_o <= '0;
      bus.req_len_o  <= '0;
      bus.req_size_o <= '0;
      bus.req_strb_o <= '0;
      bus.req_last_o <= 1'b0;
      bus.req_ch_o   <= '0;
      bus.err_addr_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            cur_ch    <= gnt_ch;
            cur_addr  <= bus.desc_addr_i[32*gnt_ch +: 32];
            remaining <= (RW'(gnt_bytes) + RW'(BPB - 1)) >> LOG_BPB;
            tail      <= gnt_bytes[LOG_BPB-1:0];
            rr_ptr    <= CH_W'((32'(gnt_ch) + 32'd1) % N_CH_U);
            err_flag  <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (cur_addr[LOG_BPB-1:0] != '0) begin
            err_flag       <= 1'b1;
            bus.err_addr_o <= cur_addr;
            state          <= DONE;
          end else if (remaining == '0 || bus.abort_i[cur_ch]) begin
            state <= DONE;
          end else begin
            burst_n        <= 9'(n_calc);
            bus.req_addr_o <= cur_addr;
            bus.req_len_o  <= 8'(n_calc - CW'(1));
            bus.req_size_o <= 3'(LOG_BPB);
            bus.req_strb_o <= strb_calc;
            bus.req_last_o <= last_calc;
            bus.req_ch_o   <= cur_ch;
            state          <= BURST;
          end
        end
        BURST: begin
          if (bus.req_ready_i) begin
            cur_addr  <= cur_addr + (32'(burst_n) << LOG_BPB);
            remaining <= remaining - RW'(burst_n);
            state     <= bus.req_last_o ? DONE : CHECK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The accept cycle counts as busy: the descriptor is committed even though the FSM is still in IDLE.
  assign bus.desc_ready_o = (state == IDLE && gnt_any && !rst) ? (N_CH'(1) << gnt_ch) : '0;
  assign bus.req_valid_o  = (state == BURST);
  assign bus.busy_o       = (state != IDLE) || (|bus.desc_ready_o);
  assign bus.done_o       = (state == DONE) ? (N_CH'(1) << cur_ch) : '0;
  assign bus.error_o      = (state == DONE && err_flag) ? (N_CH'(1) << cur_ch) : '0;
endmodule

// File: tb/tb_dma_mc_burst_gen.sv
// Bench for dma_mc_burst_gen: vector table, corner-case sequences and random descriptors
// checked against a burst-splitting reference model (DATA_W=32, MAX_BEATS=16, BOUNDARY=4096).
module tb_dma_mc_burst_gen;
  localparam int N_CH = 2;
  localparam int BPB  = 4;
  localparam int MAXB = 16;
  localparam int BND  = 4096;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  strb;
    logic        last;
    logic        ch;
  } burst_t;

  typedef struct {
    int  ch;
    bit  err;
  } done_t;

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic [31:0] bytes;
    int          nreq;
    logic [31:0] f_addr;
    logic [7:0]  f_len;
    logic [31:0] l_addr;
    logic [7:0]  l_len;
    logic [3:0]  l_strb;
    bit          err;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   rdy_mode;
  int   stray_err;
  bit   busy_at_accept;

  burst_t got_q[$];
  burst_t exp_q[$];
  done_t  done_q[$];
  int     grant_q[$];

  dma_mc_burst_gen_if #(.N_CH(N_CH), .DATA_W(32), .BYTES_W(32)) bus ();

  dma_mc_burst_gen #(
    .N_CH(N_CH), .DATA_W(32), .BYTES_W(32), .MAX_BEATS(MAXB), .BOUNDARY(BND)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Handshake partner: 0 = never ready, 1 = always ready, 2 = random.
  initial begin
    bus.req_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        1:       bus.req_ready_i = 1'b1;
        2:       bus.req_ready_i = 1'($urandom_range(0, 1));
        default: bus.req_ready_i = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req_valid_o && bus.req_ready_i)
        got_q.push_back('{bus.req_addr_o, bus.req_len_o, bus.req_strb_o, bus.req_last_o, bus.req_ch_o});
      for (int c = 0; c < N_CH; c++) begin
        if (bus.done_o[c]) done_q.push_back('{c, bus.error_o[c]});
        if (bus.desc_ready_o[c]) grant_q.push_back(c);
      end
      if ((bus.error_o & ~bus.done_o) != '0) stray_err++;
    end
  end

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  // Reference: walk the descriptor in bytes, cutting at the beat cap and the 4 KiB boundary.
  function automatic bit model(int ch, logic [31:0] a, logic [31:0] b);
    longint unsigned left, addr, n, room, tail;
    exp_q.delete();
    if (a % BPB != 0) return 1'b1;
    left = (longint'(b) + BPB - 1) / BPB;
    tail = b % BPB;
    addr = a;
    while (left > 0) begin
      room = (BND - (addr % BND)) / BPB;
      n = left;
      if (n > MAXB) n = MAXB;
      if (n > room) n = room;
      exp_q.push_back('{32'(addr), 8'(n - 1),
                        (n == left && tail != 0) ? 4'((1 << tail) - 1) : 4'hF,
                        (n == left), 1'(ch)});
      addr += n * BPB;
      left -= n;
    end
    return 1'b0;
  endfunction

  task automatic start_desc(input int ch, input logic [31:0] a, input logic [31:0] b);
    bit acc;
    acc = 1'b0;
    got_q.delete();
    done_q.delete();
    @(posedge clk);
    #1;
    bus.desc_valid_i[ch]           = 1'b1;
    bus.desc_addr_i[32*ch +: 32]   = a;
    bus.desc_bytes_i[32*ch +: 32]  = b;
    for (int k = 0; k < 100 && !acc; k++) begin
      #1;
      if (bus.desc_ready_o[ch]) begin
        acc = 1'b1;
        busy_at_accept = bus.busy_o;
      end
      @(posedge clk);
      #1;
    end
    bus.desc_valid_i[ch] = 1'b0;
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done_q.size() == 0 && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (done_q.size() == 0) chk("done_timeout", 64'd0, 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_desc(input int ch, input logic [31:0] a, input logic [31:0] b);
    start_desc(ch, a, b);
    wait_done();
  endtask

  task automatic check_model(input int ch, input logic [31:0] a, input logic [31:0] b);
    bit e;
    e = model(ch, a, b);
    chk("rnd_nreq", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("rnd_burst", 64'({got_q[i].addr, got_q[i].len, got_q[i].strb, got_q[i].last, got_q[i].ch}),
                       64'({exp_q[i].addr, exp_q[i].len, exp_q[i].strb, exp_q[i].last, exp_q[i].ch}));
    chk("rnd_done_cnt", 64'(done_q.size()), 64'd1);
    if (done_q.size() == 1) chk("rnd_done_ch_err", 64'({done_q[0].ch, done_q[0].err}), 64'({ch, e}));
    if (e) chk("rnd_err_addr", 64'(bus.err_addr_o), 64'(a));
  endtask

  vec_t tbl[8];

  initial begin
    int lat;
    int cnt;
    logic [31:0] ra, rb;
    int rc;

    total = 0;
    bad = 0;
    stray_err = 0;
    rdy_mode = 1;
    busy_at_accept = 1'b0;
    bus.desc_valid_i = '0;
    bus.desc_addr_i  = '0;
    bus.desc_bytes_i = '0;
    bus.abort_i      = '0;

    tbl[0] = '{0, 32'h1000, 102, 2, 32'h1000, 8'd15, 32'h1040, 8'd9,  4'h3, 1'b0};
    tbl[1] = '{0, 32'h0FF0, 64,  2, 32'h0FF0, 8'd3,  32'h1000, 8'd11, 4'hF, 1'b0};
    tbl[2] = '{1, 32'h1002, 8,   0, 32'h0,    8'd0,  32'h0,    8'd0,  4'h0, 1'b1};
    tbl[3] = '{0, 32'h2000, 0,   0, 32'h0,    8'd0,  32'h0,    8'd0,  4'h0, 1'b0};
    tbl[4] = '{1, 32'h3000, 4,   1, 32'h3000, 8'd0,  32'h3000, 8'd0,  4'hF, 1'b0};
    tbl[5] = '{1, 32'h3FFC, 5,   2, 32'h3FFC, 8'd0,  32'h4000, 8'd0,  4'h1, 1'b0};
    tbl[6] = '{0, 32'h5000, 64,  1, 32'h5000, 8'd15, 32'h5000, 8'd15, 4'hF, 1'b0};
    tbl[7] = '{0, 32'h6000, 65,  2, 32'h6000, 8'd15, 32'h6040, 8'd0,  4'h1, 1'b0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_ctrl", 64'({bus.req_valid_o, bus.busy_o, bus.done_o, bus.error_o, bus.desc_ready_o}), 64'd0);
    chk("rst_req", 64'({bus.req_addr_o, bus.req_len_o, bus.req_size_o, bus.req_strb_o, bus.req_last_o, bus.req_ch_o}), 64'd0);
    chk("rst_err_addr", 64'(bus.err_addr_o), 64'd0);

    for (int t = 0; t < 8; t++) begin
      run_desc(tbl[t].ch, tbl[t].addr, tbl[t].bytes);
      chk("tbl_nreq", 64'(got_q.size()), 64'(tbl[t].nreq));
      if (tbl[t].nreq > 0 && got_q.size() == tbl[t].nreq) begin
        chk("tbl_first", 64'({got_q[0].addr, got_q[0].len}), 64'({tbl[t].f_addr, tbl[t].f_len}));
        chk("tbl_last_burst", 64'({got_q[$].addr, got_q[$].len, got_q[$].strb}),
                              64'({tbl[t].l_addr, tbl[t].l_len, tbl[t].l_strb}));
        for (int i = 0; i < got_q.size(); i++)
          chk("tbl_ch_last", 64'({got_q[i].ch, got_q[i].last}), 64'({1'(tbl[t].ch), (i == got_q.size() - 1)}));
      end
      chk("tbl_done_cnt", 64'(done_q.size()), 64'd1);
      if (done_q.size() == 1) chk("tbl_done_ch_err", 64'({done_q[0].ch, done_q[0].err}), 64'({tbl[t].ch, tbl[t].err}));
      if (tbl[t].err) chk("tbl_err_addr", 64'(bus.err_addr_o), 64'(tbl[t].addr));
    end
    chk("size_field", 64'(bus.req_size_o), 64'd2);

    // Zero-byte descriptor: busy for the accept, CHECK and DONE cycles only.
    start_desc(0, 32'h2100, 0);
    cnt = busy_at_accept ? 1 : 0;
    for (int k = 0; k < 10 && bus.busy_o; k++) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    chk("zero_busy_cycles", 64'(cnt), 64'd3);
    wait_done();
    chk("zero_nreq", 64'(got_q.size()), 64'd0);

    // Accept-to-valid latency and request stability while ready is held low.
    rdy_mode = 0;
    start_desc(0, 32'h7000, 4);
    lat = 0;
    while (!bus.req_valid_o && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("accept_to_valid", 64'(lat + 1), 64'd2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("stall_stable", 64'({bus.req_valid_o, bus.req_addr_o, bus.req_len_o, bus.req_strb_o, bus.req_last_o}),
                          64'({1'b1, 32'h7000, 8'd0, 4'hF, 1'b1}));
    end
    rdy_mode = 1;
    wait_done();
    chk("stall_nreq", 64'(got_q.size()), 64'd1);

    // Abort during the first of three bursts.
    rdy_mode = 0;
    start_desc(0, 32'hA000, 192);
    for (int k = 0; k < 20 && !bus.req_valid_o; k++) begin
      @(posedge clk);
      #1;
    end
    bus.abort_i[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("abort_keeps_valid", 64'(bus.req_valid_o), 64'd1);
    end
    rdy_mode = 1;
    wait_done();
    bus.abort_i[0] = 1'b0;
    chk("abort_nreq", 64'(got_q.size()), 64'd1);
    chk("abort_done_cnt", 64'(done_q.size()), 64'd1);
    if (done_q.size() == 1) chk("abort_done_err", 64'({done_q[0].ch, done_q[0].err}), 64'({32'd0, 1'b0}));

    // Reset in the middle of a burst discards the descriptor.
    rdy_mode = 0;
    start_desc(1, 32'hB000, 64);
    for (int k = 0; k < 20 && !bus.req_valid_o; k++) begin
      @(posedge clk);
      #1;
    end
    done_q.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_burst", 64'({bus.req_valid_o, bus.busy_o}), 64'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_done", 64'(done_q.size()), 64'd0);

    // Round-robin from a fresh pointer with both channels always requesting.
    rdy_mode = 1;
    grant_q.delete();
    bus.desc_addr_i  = {32'h9000, 32'h8000};
    bus.desc_bytes_i = {32'd4, 32'd4};
    bus.desc_valid_i = 2'b11;
    for (int k = 0; k < 200 && grant_q.size() < 4; k++) begin
      @(posedge clk);
      #1;
    end
    bus.desc_valid_i = '0;
    repeat (8) @(posedge clk);
    #1;
    chk("rr_grants", 64'(grant_q.size()), 64'd4);
    if (grant_q.size() >= 4)
      chk("rr_order", 64'({grant_q[0][3:0], grant_q[1][3:0], grant_q[2][3:0], grant_q[3][3:0]}), 64'h0101);

    // Random descriptors against the model.
    rdy_mode = 2;
    for (int r = 0; r < 40; r++) begin
      rc = $urandom_range(0, 1);
      ra = ($urandom_range(0, 255) << 12) + ($urandom_range(0, 1023) << 2);
      if ($urandom_range(0, 7) == 0) ra = ra | 32'($urandom_range(1, 3));
      rb = $urandom_range(0, 300);
      if ($urandom_range(0, 9) == 0) rb = 0;
      run_desc(rc, ra, rb);
      check_model(rc, ra, rb);
    end

    chk("stray_error", 64'(stray_err), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
